pa_ifu_ipack_buf: RTL and testbench
===================================

Name: pa_ifu_ipack_buf

Overview:
- Instruction packer on the producer side of the IFU→ID pre-decode interface.
- Accepts 32-bit fetch words, which may start on a halfword, into a small halfword queue.
- Reassembles 32-bit instructions that straddle fetch words.
- Presents each cycle one instruction slot inst0 (16 or 32 bit) and one compressed slot inst1 (16 bit), with valids, head PC and pop handshake, to the pre-decoder and ID stage.

Parameters:
- DEPTH, 4, halfword entries in queue (power of 2, ≥4)
- PTR_W, 2, log2(DEPTH)

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, synchronous, active-high
- ifu_ipack_fetch_vld  in  1  fetch word valid
- ifu_ipack_fetch_data  in  32  fetch word; [15:0] = lower halfword
- ifu_ipack_fetch_pc  in  31  PC[31:1] of first valid halfword; PC[1]=1 → only [31:16] valid
- ipack_ifu_fetch_rdy  out  1  buffer can accept a word this cycle
- ifu_ipack_flush  in  1  redirect: discard all content
- id_ipack_pop0  in  1  ID consumes inst0
- id_ipack_pop1  in  1  ID consumes inst1 (only with pop0)
- ipack_id_pred_inst0  out  32  head instruction; [31:16] = 0 when 16-bit
- ipack_id_pred_inst0_vld  out  1  inst0 complete
- ipack_id_pred_inst1  out  16  halfword following inst0
- ipack_id_pred_inst1_vld  out  1  inst1 present and compressed
- ipack_id_inst0_pc  out  31  PC[31:1] of inst0
- ipack_id_entry_cnt  out  PTR_W+1  occupied halfwords

Behaviour:
- State: DEPTH×16 entry array, rd_ptr, wr_ptr (wrap mod DEPTH), cnt (0..DEPTH), head_pc[31:1].
- Reset (cpurst=1 at clock edge): all state 0, entries 0. Outputs: vld=0, rdy=1, cnt=0, inst0=0, inst1=0, pc=0.
- All outputs are combinational from registered state only. No input→output comb path. Fetch-to-inst0_vld latency is 1 cycle.
- L0 = (entry[rd][1:0]==2'b11) ? 2 : 1.
- inst0_vld = cnt≥L0.
- inst0 = L0==2 ? {entry[rd+1], entry[rd]} : {16'b0, entry[rd]}.
- inst1 = entry[rd+L0].
- inst1_vld = inst0_vld & cnt≥L0+1 & inst1[1:0]!=2'b11.
- Fill count F = fetch accepted ? (pc[1] ? 1 : 2) : 0. Accepted = fetch_vld & rdy & ~flush.
- If pc[1]=1, only data[31:16] is written.
- rdy = (DEPTH−cnt)≥2. Depends on cnt only, not on same-cycle pop. A halfword-offset fetch with exactly 1 free entry is not accepted.
- Pop count P = (pop0&inst0_vld)·L0 + (pop0&pop1&inst1_vld)·1.
- pop1 without pop0 is ignored. Pops when not valid are ignored.
- cnt_next = cnt + F − P. rd_ptr += P. wr_ptr += F.
- head_pc: if cnt−P==0 and F>0, head_pc ← fetch_pc. Otherwise head_pc += P.
- The fetch stream between flushes is sequential. The block does not check PC continuity.
- Simultaneous pop and fill: both take effect the same cycle. Newly written entries are visible the next cycle.
- Full (cnt=DEPTH): rdy=0. Pops still proceed.
- Empty: both vld=0.
- Straddling instruction (cnt=1, 32-bit head): inst0_vld=0 until the next halfword arrives.
- Flush: next cycle cnt=0, rd_ptr=wr_ptr=0. Same-cycle fetch and pops are discarded. Flush has priority over everything except reset.
- Reset mid-operation: identical to reset; in-flight content is lost.

Decomposition:
- Shared IFU package constants: IPACK_DEPTH, RVC opcode-length mask (2'b11 = 32-bit), halfword width 16.
- One natural sub-module: pa_ifu_ipack_entry_array (write-2/read-3 halfword register file with rd/wr pointers). Length decode, counters and handshake stay in the top.

Test Plan:
- Reset, then fetch data=0x00010001 at PC 0x100 → next cycle inst0_vld=1, inst0=0x00000001, inst1=0x0001, inst1_vld=1, pc=0x100>>1, cnt=2. Then pop0+pop1 → cnt=0, both vld=0.
- Fetch PC 0x102, data=0x0093xxxx → cnt=1, inst0_vld=0. Then fetch PC 0x104, data=0x00010000 → inst0=0x00000093, inst0_vld=1, pc=0x102>>1, inst1=0x0001 vld.
- Fill to cnt=4 with no pops → rdy=0 and an asserted fetch is dropped. pop0 on a 16-bit head → cnt=3, rdy still 0. Second pop0 → cnt=2, rdy=1.
- At cnt=2, pop0 on a 16-bit head plus fetch PC 0x108 in the same cycle → cnt=3, head_pc += 1, no entry corruption across pointer wrap.
- Flush asserted with fetch_vld=1 and pop0=1 at cnt=3 → next cycle cnt=0, vld=0, rdy=1. The fetched word is not stored.
- pop1 without pop0, and pop0 while inst0_vld=0 → state unchanged.

Source files
------------

// File: rtl/pa_ifu_ipack_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module : pa_ifu_ipack_buf_pkg
// Brief  : Shared IFU instruction-packer constants and RVC length decode.
// Rev    : 1.0
// ============================================================================
package pa_ifu_ipack_buf_pkg;

    localparam int         IPACK_DEPTH  = 4;
    localparam int         IPACK_PTR_W  = 2;
    localparam int         HW_W         = 16;
    localparam logic [1:0] RVC_LEN_MASK = 2'b11;

    typedef logic [HW_W-1:0] halfword_t;

    // Both low opcode bits set marks a 32-bit instruction.
    function automatic logic is_32b(input halfword_t hw);
        return (hw[1:0] & RVC_LEN_MASK) == RVC_LEN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pa_ifu_ipack_buf_if.sv
`default_nettype none
// ============================================================================
// Module : pa_ifu_ipack_buf_if
// Brief  : Fetch, pop and pre-decode signals around the instruction packer.
// Rev    : 1.0
// ============================================================================
interface pa_ifu_ipack_buf_if #(
    parameter int PTR_W = 2
);
    logic             ifu_ipack_fetch_vld;
    logic [31:0]      ifu_ipack_fetch_data;
    logic [30:0]      ifu_ipack_fetch_pc;
    logic             ipack_ifu_fetch_rdy;
    logic             ifu_ipack_flush;
    logic             id_ipack_pop0;
    logic             id_ipack_pop1;
    logic [31:0]      ipack_id_pred_inst0;
    logic             ipack_id_pred_inst0_vld;
    logic [15:0]      ipack_id_pred_inst1;
    logic             ipack_id_pred_inst1_vld;
    logic [30:0]      ipack_id_inst0_pc;
    logic [PTR_W:0]   ipack_id_entry_cnt;

    modport master (
        output ifu_ipack_fetch_vld, ifu_ipack_fetch_data, ifu_ipack_fetch_pc,
        output ifu_ipack_flush, id_ipack_pop0, id_ipack_pop1,
        input  ipack_ifu_fetch_rdy, ipack_id_pred_inst0, ipack_id_pred_inst0_vld,
        input  ipack_id_pred_inst1, ipack_id_pred_inst1_vld, ipack_id_inst0_pc,
        input  ipack_id_entry_cnt
    );

    modport slave (
        input  ifu_ipack_fetch_vld, ifu_ipack_fetch_data, ifu_ipack_fetch_pc,
        input  ifu_ipack_flush, id_ipack_pop0, id_ipack_pop1,
        output ipack_ifu_fetch_rdy, ipack_id_pred_inst0, ipack_id_pred_inst0_vld,
        output ipack_id_pred_inst1, ipack_id_pred_inst1_vld, ipack_id_inst0_pc,
        output ipack_id_entry_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pa_ifu_ipack_buf_entry_array.sv
`default_nettype none
// ============================================================================
// Module : pa_ifu_ipack_entry_array
// Brief  : Circular halfword register file, two write ports, three read ports.
// Rev    : 1.0
// ============================================================================
module pa_ifu_ipack_entry_array
    import pa_ifu_ipack_buf_pkg::*;
#(
    parameter int DEPTH = IPACK_DEPTH,
    parameter int PTR_W = IPACK_PTR_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      clr,
    input  wire logic [1:0] wr_cnt,
    input  wire halfword_t wr_data0,
    input  wire halfword_t wr_data1,
    input  wire logic [1:0] rd_adv,
    output halfword_t      rd_data0,
    output halfword_t      rd_data1,
    output halfword_t      rd_data2
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    halfword_t        entry [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (wr_cnt != 2'd0) begin
                entry[wr_ptr] <= wr_data0;
            end
            if (wr_cnt == 2'd2) begin
                entry[wr_ptr + PTR_W'(1)] <= wr_data1;
            end
            rd_ptr <= rd_ptr + PTR_W'(rd_adv);
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_data0 = entry[rd_ptr];
    assign rd_data1 = entry[rd_ptr + PTR_W'(1)];
    assign rd_data2 = entry[rd_ptr + PTR_W'(2)];

endmodule
`default_nettype wire

// File: rtl/pa_ifu_ipack_buf.sv
`default_nettype none
// ============================================================================
// Module : pa_ifu_ipack_buf
// Brief  : IFU instruction packer presenting inst0/inst1 slots to pre-decode.
// Rev    : 1.0
// ============================================================================
module pa_ifu_ipack_buf
    import pa_ifu_ipack_buf_pkg::*;
#(
    parameter int DEPTH = IPACK_DEPTH,
    parameter int PTR_W = IPACK_PTR_W
) (
    input  wire logic          forever_cpuclk,
    input  wire logic          cpurst,
    pa_ifu_ipack_buf_if.slave  bus
);

    logic [PTR_W:0] cnt;
    logic [30:0]    head_pc;
    halfword_t      hw0;
    halfword_t      hw1;
    halfword_t      hw2;
    logic [1:0]     l0;
    logic           inst0_vld;
    logic           inst1_vld;
    halfword_t      inst1;
    logic           rdy;
    logic           accept;
    logic [1:0]     fill;
    logic [1:0]     pop_cnt;
    halfword_t      wr_data0;

    pa_ifu_ipack_entry_array #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_entry_array (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .clr      (bus.ifu_ipack_flush),
        .wr_cnt   (fill),
        .wr_data0 (wr_data0),
        .wr_data1 (bus.ifu_ipack_fetch_data[31:16]),
        .rd_adv   (pop_cnt),
        .rd_data0 (hw0),
        .rd_data1 (hw1),
        .rd_data2 (hw2)
    );

    assign l0        = is_32b(hw0) ? 2'd2 : 2'd1;
    assign inst0_vld = cnt >= (PTR_W+1)'(l0);
    assign inst1     = (l0 == 2'd2) ? hw2 : hw1;
    assign inst1_vld = inst0_vld && (cnt >= (PTR_W+1)'(l0 + 2'd1)) && !is_32b(inst1);

    // Fetch readiness looks only at the current count, never at same-cycle pops.
    assign rdy    = cnt <= (PTR_W+1)'(DEPTH - 2);
    assign accept = bus.ifu_ipack_fetch_vld && rdy && !bus.ifu_ipack_flush;
    assign fill   = !accept ? 2'd0 : (bus.ifu_ipack_fetch_pc[0] ? 2'd1 : 2'd2);

    // fetch_pc[0] is PC[1]: an odd halfword start keeps only the upper half.
    assign wr_data0 = bus.ifu_ipack_fetch_pc[0] ? bus.ifu_ipack_fetch_data[31:16]
                                                : bus.ifu_ipack_fetch_data[15:0];

    always_comb begin
        pop_cnt = 2'd0;
        if (!bus.ifu_ipack_flush && bus.id_ipack_pop0 && inst0_vld) begin
            pop_cnt = l0;
            if (bus.id_ipack_pop1 && inst1_vld) begin
                pop_cnt = l0 + 2'd1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            cnt     <= '0;
            head_pc <= '0;
        end else if (bus.ifu_ipack_flush) begin
            cnt     <= '0;
        end else begin
            cnt <= cnt + (PTR_W+1)'(fill) - (PTR_W+1)'(pop_cnt);
            if ((cnt == (PTR_W+1)'(pop_cnt)) && (fill != 2'd0)) begin
                head_pc <= bus.ifu_ipack_fetch_pc;
            end else begin
                head_pc <= head_pc + 31'(pop_cnt);
            end
        end
    end

    assign bus.ipack_ifu_fetch_rdy     = rdy;
    assign bus.ipack_id_pred_inst0     = (l0 == 2'd2) ? {hw1, hw0} : {16'h0000, hw0};
    assign bus.ipack_id_pred_inst0_vld = inst0_vld;
    assign bus.ipack_id_pred_inst1     = inst1;
    assign bus.ipack_id_pred_inst1_vld = inst1_vld;
    assign bus.ipack_id_inst0_pc       = head_pc;
    assign bus.ipack_id_entry_cnt      = cnt;

endmodule
`default_nettype wire

// File: tb/tb_pa_ifu_ipack_buf.sv
`default_nettype none
// ============================================================================
// Module : tb_pa_ifu_ipack_buf
// Brief  : Directed plus randomized bench against a halfword-queue model.
// Rev    : 1.0
// ============================================================================
module tb_pa_ifu_ipack_buf;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // Model: queue of halfwords in program order, each tagged with its PC[31:1].
    logic [15:0] q   [$];
    logic [30:0] qpc [$];
    logic [30:0] nxt_pc;

    pa_ifu_ipack_buf_if #(.PTR_W(2)) bus ();

    pa_ifu_ipack_buf #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        int l0;
        bit v0;
        bit v1;
        logic [31:0] e0;
        n  = q.size();
        l0 = (n > 0 && q[0][1:0] == 2'b11) ? 2 : 1;
        v0 = n >= l0;
        v1 = v0 && (n > l0) && (q[l0][1:0] != 2'b11);
        chk("inst0_vld", 32'(bus.ipack_id_pred_inst0_vld), 32'(v0));
        chk("inst1_vld", 32'(bus.ipack_id_pred_inst1_vld), 32'(v1));
        chk("cnt",       32'(bus.ipack_id_entry_cnt), 32'(n));
        chk("rdy",       32'(bus.ipack_ifu_fetch_rdy), 32'((DEPTH - n) >= 2));
        if (v0) begin
            e0 = (l0 == 2) ? {q[1], q[0]} : {16'h0000, q[0]};
            chk("inst0", bus.ipack_id_pred_inst0, e0);
            chk("pc",    32'(bus.ipack_id_inst0_pc), 32'(qpc[0]));
        end
        if (n > l0) begin
            chk("inst1", 32'(bus.ipack_id_pred_inst1), 32'(q[l0]));
        end
    endtask

    task automatic step(input bit fv, input logic [31:0] d, input logic [30:0] pc,
                        input bit p0, input bit p1, input bit fl, input bit rs);
        int n;
        int l0;
        int pcnt;
        bit v0;
        bit v1;
        @(negedge clk);
        rst                      = rs;
        bus.ifu_ipack_fetch_vld  = fv;
        bus.ifu_ipack_fetch_data = d;
        bus.ifu_ipack_fetch_pc   = pc;
        bus.id_ipack_pop0        = p0;
        bus.id_ipack_pop1        = p1;
        bus.ifu_ipack_flush      = fl;
        n  = q.size();
        l0 = (n > 0 && q[0][1:0] == 2'b11) ? 2 : 1;
        v0 = n >= l0;
        v1 = v0 && (n > l0) && (q[l0][1:0] != 2'b11);
        if (rs || fl) begin
            q.delete();
            qpc.delete();
        end else begin
            pcnt = ((p0 && v0) ? l0 : 0) + ((p0 && p1 && v1) ? 1 : 0);
            repeat (pcnt) begin
                void'(q.pop_front());
                void'(qpc.pop_front());
            end
            if (fv && (DEPTH - n) >= 2) begin
                if (pc[0]) begin
                    q.push_back(d[31:16]);
                    qpc.push_back(pc);
                    nxt_pc = pc + 31'd1;
                end else begin
                    q.push_back(d[15:0]);
                    qpc.push_back(pc);
                    q.push_back(d[31:16]);
                    qpc.push_back(pc + 31'd1);
                    nxt_pc = pc + 31'd2;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom());
        h[1:0] = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return h;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        nxt_pc = 31'h80;
        rst = 1'b1;
        bus.ifu_ipack_fetch_vld  = 1'b0;
        bus.ifu_ipack_fetch_data = '0;
        bus.ifu_ipack_fetch_pc   = '0;
        bus.id_ipack_pop0        = 1'b0;
        bus.id_ipack_pop1        = 1'b0;
        bus.ifu_ipack_flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",   32'(bus.ipack_ifu_fetch_rdy), 32'd1);
        chk("rst_cnt",   32'(bus.ipack_id_entry_cnt), 32'd0);
        chk("rst_v0",    32'(bus.ipack_id_pred_inst0_vld), 32'd0);
        chk("rst_v1",    32'(bus.ipack_id_pred_inst1_vld), 32'd0);
        chk("rst_inst0", bus.ipack_id_pred_inst0, 32'd0);
        chk("rst_inst1", 32'(bus.ipack_id_pred_inst1), 32'd0);
        chk("rst_pc",    32'(bus.ipack_id_inst0_pc), 32'd0);

        // Aligned word holding two compressed instructions, then pop both.
        step(1, 32'h0001_0001, 31'h80, 0, 0, 0, 0);
        chk("d1_inst0", bus.ipack_id_pred_inst0, 32'h0000_0001);
        chk("d1_inst1", 32'(bus.ipack_id_pred_inst1), 32'h0001);
        chk("d1_pc",    32'(bus.ipack_id_inst0_pc), 32'h80);
        step(0, 32'h0, 31'h82, 1, 1, 0, 0);
        chk("d1_empty", 32'(bus.ipack_id_entry_cnt), 32'd0);

        // 32-bit instruction straddling two fetch words.
        step(1, 32'h0093_5555, 31'h81, 0, 0, 0, 0);
        chk("d2_straddle_v0", 32'(bus.ipack_id_pred_inst0_vld), 32'd0);
        step(1, 32'h0001_0000, 31'h82, 0, 0, 0, 0);
        chk("d2_inst0", bus.ipack_id_pred_inst0, 32'h0000_0093);
        chk("d2_pc",    32'(bus.ipack_id_inst0_pc), 32'h81);
        step(0, 32'h0, 31'h84, 1, 1, 0, 0);

        // Fill to full, drop a fetch, drain partially, then pop+fill across the wrap.
        step(1, 32'h0001_0001, 31'h84, 0, 0, 0, 0);
        step(1, 32'h0005_0001, 31'h86, 0, 0, 0, 0);
        chk("d3_full_rdy", 32'(bus.ipack_ifu_fetch_rdy), 32'd0);
        step(1, 32'h0009_0001, 31'h88, 0, 0, 0, 0);
        step(0, 32'h0, 31'h88, 1, 0, 0, 0);
        step(0, 32'h0, 31'h88, 1, 0, 0, 0);
        step(1, 32'h0009_0001, 31'h88, 1, 0, 0, 0);
        chk("d3_inst0", bus.ipack_id_pred_inst0, 32'h0000_0005);
        chk("d3_pc",    32'(bus.ipack_id_inst0_pc), 32'h87);
        chk("d3_cnt",   32'(bus.ipack_id_entry_cnt), 32'd3);

        // Flush beats same-cycle fetch and pop; then ignored pops.
        step(1, 32'h1111_2221, 31'h8a, 1, 1, 1, 0);
        chk("d4_flush_cnt", 32'(bus.ipack_id_entry_cnt), 32'd0);
        step(0, 32'h0, 31'h90, 1, 1, 0, 0);
        step(1, 32'h0000_0013, 31'h90, 0, 1, 0, 0);
        step(0, 32'h0, 31'h92, 0, 1, 0, 0);
        step(0, 32'h0, 31'h92, 1, 0, 0, 0);
        step(0, 32'h0, 31'h92, 1, 0, 0, 0);
        nxt_pc = 31'h92;

        for (int i = 0; i < 3000; i++) begin
            bit rs;
            bit fl;
            rs = ($urandom_range(0, 299) == 0);
            fl = ($urandom_range(0, 29) == 0);
            step(($urandom_range(0, 3) != 0), {rand_hw(), rand_hw()}, nxt_pc,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), fl, rs);
            if (rs || fl) begin
                nxt_pc = 31'($urandom());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
